// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;
  localparam int SEL_W      = 2;
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry [n] is the pattern for BCD value n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scanner: digit data/controls in, select and cathodes out.
interface seg_scan_ctrl_if;
  import seg_pkg::*;
  logic                   enable;
  logic [DIG_W-1:0]       digits;
  logic [NUM_DIGITS-1:0]  dp_mask;
  logic                   blank_lead;
  logic [SEL_W-1:0]       sel;
  logic [6:0]             seg;
  logic                   dp;
  logic                   frame_start;

  modport master (output enable, digits, dp_mask, blank_lead,
                  input  sel, seg, dp, frame_start);
  modport slave  (input  enable, digits, dp_mask, blank_lead,
                  output sel, seg, dp, frame_start);
endinterface

// File: rtl/bcd_seg7_enc.sv
// Combinational BCD nibble to active-low 7-segment pattern; 10..15 show a dash.
module bcd_seg7_enc
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    if (blank)                seg = SEG_BLANK;
    else if (nibble < 4'd10)  seg = SEG_TABLE[nibble];
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Refresh scanner: prescaled digit tick, 2-bit select, and registered cathodes
// for the newly selected digit, with per-frame digit snapshot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 17
) (
  input  logic            clk,
  input  logic            reset,
  seg_scan_ctrl_if.slave  bus
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_nxt;
  logic [6:0]       seg_q, seg_d, enc_seg;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;
  logic [DIG_W-1:0] snap_q, snap_d, src, upper;
  logic             tick, wrap, lz_blank;

  always_comb begin
    tick    = bus.enable && (cnt_q == CNT_W'(PRESCALE - 1));
    wrap    = tick && (sel_q == SEL_W'(NUM_DIGITS - 1));
    sel_nxt = sel_q + SEL_W'(1);
    // Digit 0 at the wrap must come from the live input, since the snapshot
    // is only being loaded on that same edge.
    src      = wrap ? bus.digits : snap_q;
    upper    = src >> {sel_nxt, 2'b00};
    lz_blank = bus.blank_lead && (sel_nxt != '0) && (upper == '0);
  end

  bcd_seg7_enc u_enc (
    .nibble (upper[3:0]),
    .blank  (lz_blank),
    .seg    (enc_seg)
  );

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    fs_d   = 1'b0;
    snap_d = snap_q;
    if (bus.enable) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    if (tick) begin
      sel_d = sel_nxt;
      seg_d = enc_seg;
      dp_d  = ~bus.dp_mask[sel_nxt];
    end
    if (wrap) begin
      snap_d = bus.digits;
      fs_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
      snap_q <= snap_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at PRESCALE=4: directed scenarios plus randomized
// traffic against a slot-level reference model.
module tb_seg_scan_ctrl;
  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.PRESCALE(P), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_cnt, m_sel;
  logic [15:0] m_snap;
  logic [6:0]  m_seg;
  logic        m_dp, m_fs;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] pat(input logic [15:0] f, input int k, input logic bl);
    logic [15:0] up;
    up = f >> (4 * k);
    if (bl && k != 0 && up == 16'h0) return 7'h7F;
    return enc(up[3:0]);
  endfunction

  // One clock; the model advances from the inputs present at that edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_sel = 0; m_snap = 16'h0; m_seg = 7'h7F; m_dp = 1'b1; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (bus.enable) begin
        if (m_cnt == P - 1) begin
          m_cnt = 0;
          m_sel = (m_sel + 1) % 4;
          if (m_sel == 0) begin
            m_snap = bus.digits;
            m_fs   = 1'b1;
          end
          m_seg = pat(m_snap, m_sel, bus.blank_lead);
          m_dp  = ~bus.dp_mask[m_sel];
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.sel, bus.seg, bus.dp, bus.frame_start} !== {2'd0, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got sel=%0d seg=%b dp=%b fs=%b, want sel=0 seg=1111111 dp=1 fs=0",
               bus.sel, bus.seg, bus.dp, bus.frame_start);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    bus.digits = 16'h1234; bus.blank_lead = 1'b0; bus.dp_mask = 4'h0; bus.enable = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (bus.frame_start !== (i == 16 || i == 32)) begin
        errors++;
        $display("FAIL scan_fs: cycle %0d got %b", i, bus.frame_start);
      end
      if (i % 4 == 0) begin
        checks++;
        if (bus.sel !== 2'((i / 4) % 4)) begin
          errors++;
          $display("FAIL scan_sel: cycle %0d got %0d want %0d", i, bus.sel, (i / 4) % 4);
        end
        // First frame shows the reset snapshot (zeros) except the live digit 0.
        checks++;
        if (i > 16 || i == 16) begin
          if (bus.seg !== exp_seg[(i / 4) % 4]) begin
            errors++;
            $display("FAIL scan_seg: cycle %0d got %b want %b", i, bus.seg, exp_seg[(i / 4) % 4]);
          end
        end else if (bus.seg !== 7'b1000000) begin
          errors++;
          $display("FAIL scan_first_frame: cycle %0d got %b want 1000000", i, bus.seg);
        end
      end
    end
  endtask

  task automatic test_tear();
    logic [6:0] exp_seg [6];
    exp_seg = '{7'b0100100, 7'b1111001, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    repeat (4) step();
    bus.digits = 16'h5678;
    for (int s = 0; s < 6; s++) begin
      repeat (4) step();
      checks++;
      if (bus.seg !== exp_seg[s] || bus.frame_start !== (s == 2)) begin
        errors++;
        $display("FAIL tear_slot%0d: got seg=%b fs=%b want seg=%b fs=%b",
                 s, bus.seg, bus.frame_start, exp_seg[s], (s == 2));
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg [8];
    exp_seg = '{7'b1000000, 7'b0011001, 7'h7F, 7'h7F,
                7'b1000000, 7'b0011001, 7'b1000000, 7'b1000000};
    bus.digits = 16'h0040; bus.blank_lead = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s == 4) bus.blank_lead = 1'b0;
      repeat (4) step();
      checks++;
      if (bus.sel !== 2'(s % 4) || bus.seg !== exp_seg[s]) begin
        errors++;
        $display("FAIL blank_slot%0d: got sel=%0d seg=%b want sel=%0d seg=%b",
                 s, bus.sel, bus.seg, s % 4, exp_seg[s]);
      end
    end
  endtask

  task automatic test_dash_dp();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b0111111};
    bus.digits = 16'hA000; bus.dp_mask = 4'b0100;
    for (int s = 0; s < 4; s++) begin
      repeat (4) step();
      checks++;
      if (bus.seg !== exp_seg[s] || bus.dp !== (s != 2)) begin
        errors++;
        $display("FAIL dash_dp_slot%0d: got seg=%b dp=%b want seg=%b dp=%b",
                 s, bus.seg, bus.dp, exp_seg[s], (s != 2));
      end
    end
  endtask

  task automatic test_enable();
    repeat (2) step();
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.sel !== 2'd3 || bus.seg !== 7'b0111111 || bus.frame_start !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold: cycle %0d got sel=%0d seg=%b fs=%b want 3/0111111/0",
                 i, bus.sel, bus.seg, bus.frame_start);
      end
    end
    bus.enable = 1'b1;
    step();
    checks++;
    if (bus.sel !== 2'd3) begin
      errors++;
      $display("FAIL enable_early_tick: got sel=%0d want 3", bus.sel);
    end
    step();
    checks++;
    if (bus.sel !== 2'd0 || bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL enable_resume: got sel=%0d fs=%b want 0/1", bus.sel, bus.frame_start);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (bus.sel !== 2'd2 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (bus.sel !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_reach: sel=%0d never reached 2", bus.sel);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.sel, bus.seg, bus.dp, bus.frame_start} !== {2'd0, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid%0d: got sel=%0d seg=%b dp=%b fs=%b", i,
                 bus.sel, bus.seg, bus.dp, bus.frame_start);
      end
    end
    reset = 1'b0;
    // Counter restarts from 0: first tick on the P-th enabled edge.
    for (int i = 1; i <= P; i++) begin
      step();
      checks++;
      if (bus.sel !== 2'(i == P)) begin
        errors++;
        $display("FAIL reset_first_tick: edge %0d got sel=%0d", i, bus.sel);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) < 2);
      bus.enable     = ($urandom_range(0, 99) < 85);
      bus.blank_lead = $urandom_range(0, 1);
      bus.dp_mask    = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        for (int k = 0; k < 4; k++)
          bus.digits[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom);
      step();
      checks++;
      if ({bus.sel, bus.seg, bus.dp, bus.frame_start} !== {2'(m_sel), m_seg, m_dp, m_fs}) begin
        errors++;
        $display("FAIL random_cycle%0d: got sel=%0d seg=%b dp=%b fs=%b want sel=%0d seg=%b dp=%b fs=%b",
                 i, bus.sel, bus.seg, bus.dp, bus.frame_start, m_sel, m_seg, m_dp, m_fs);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0; bus.digits = 16'h0; bus.dp_mask = 4'h0; bus.blank_lead = 1'b0;
    test_reset();
    test_scan();
    test_tear();
    test_blank();
    test_dash_dp();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
